priv_1_12_trap_redirect: RTL



---
 rtl/machine_mode_types_1_12_pkg.sv | 52 +++++
 rtl/priv_1_12_trap_redirect_if.sv | 36 +++
 rtl/priv_1_12_trap_target.sv | 52 +++++
 rtl/priv_1_12_trap_redirect.sv | 112 +++++++++++
 4 files changed

// File: rtl/machine_mode_types_1_12_pkg.sv
// Machine-mode CSR field types for the v1.12 privilege block, plus the
// redirect FSM state type shared by the trap-redirect stage and the priv wrapper.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
// Contents: mtvec_mode_t, mtvec_t, mcause_t, redirect_state_t, trap_evt_t,
// align_pc(), vector_target().
package machine_mode_types_1_12_pkg;

  typedef enum logic [1:0] {
    DIRECT   = 2'b00,
    VECTORED = 2'b01
  } mtvec_mode_t;

  // mode is kept as raw bits: encodings 2 and 3 are reserved but can still
  // appear in the register and must simply fail the VECTORED match.
  typedef struct packed {
    logic [29:0] base;
    logic [1:0]  mode;
  } mtvec_t;

  typedef struct packed {
    logic        interrupt;
    logic [30:0] cause;
  } mcause_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_CLEAR = 2'd1,
    REDIRECT   = 2'd2
  } redirect_state_t;

  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,
    EVT_INTR = 2'd1,
    EVT_MRET = 2'd2,
    EVT_SRET = 2'd3
  } trap_evt_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0200;

  // Redirect targets are always word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

  // Vectored interrupt entry: base + 4*cause, wrapping modulo 2^32.
  // cause << 2 truncated to 32 bits is just the low 30 cause bits shifted.
  function automatic logic [31:0] vector_target(input mtvec_t mtvec, input mcause_t mcause);
    return {mtvec.base, 2'b00} + {mcause.cause[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/priv_1_12_trap_redirect_if.sv
// Bundle between the int/ex handler + CSR file (master) and the trap-redirect stage (slave).
// Latency: n/a (wires only).
// Backpressure: fetch_ack is the only flow-control signal; insert_pc/priv_pc hold until it.
// Signals: intr, mret, sret, pipe_clear, curr_mtvec, curr_mepc, curr_sepc, next_mcause,
// fetch_ack (toward slave); insert_pc, priv_pc, redirect_busy (from slave).
interface priv_1_12_trap_redirect_if;
  import machine_mode_types_1_12_pkg::*;

  logic        intr;
  logic        mret;
  logic        sret;
  logic        pipe_clear;
  mtvec_t      curr_mtvec;
  logic [31:0] curr_mepc;
  logic [31:0] curr_sepc;
  mcause_t     next_mcause;
  logic        fetch_ack;
  logic        insert_pc;
  logic [31:0] priv_pc;
  logic        redirect_busy;

  modport master (
    output intr, mret, sret, pipe_clear,
    output curr_mtvec, curr_mepc, curr_sepc, next_mcause,
    output fetch_ack,
    input  insert_pc, priv_pc, redirect_busy
  );

  modport slave (
    input  intr, mret, sret, pipe_clear,
    input  curr_mtvec, curr_mepc, curr_sepc, next_mcause,
    input  fetch_ack,
    output insert_pc, priv_pc, redirect_busy
  );

endinterface

// File: rtl/priv_1_12_trap_target.sv
// Combinational event select (intr > mret > sret) and redirect target computation.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether the selected event is accepted.
// Ports: intr/mret/sret, curr_mtvec, curr_mepc, curr_sepc, next_mcause in; evt, target out.
// Optional feature: PRIV_1_12_VECTORED_TRAP_EN enables vectored interrupt entry.
module priv_1_12_trap_target
  import machine_mode_types_1_12_pkg::*;
(
  input  logic        intr,
  input  logic        mret,
  input  logic        sret,
  input  mtvec_t      curr_mtvec,
  input  logic [31:0] curr_mepc,
  input  logic [31:0] curr_sepc,
  input  mcause_t     next_mcause,
  output trap_evt_t   evt,
  output logic [31:0] target
);

  logic [31:0] trap_base;
  logic [31:0] trap_target;

  assign trap_base = {curr_mtvec.base, 2'b00};

`ifdef PRIV_1_12_VECTORED_TRAP_EN
  // Only interrupts vector; synchronous exceptions always enter at base.
  assign trap_target = ((curr_mtvec.mode == VECTORED) && next_mcause.interrupt)
                       ? vector_target(curr_mtvec, next_mcause)
                       : trap_base;
`else
  assign trap_target = trap_base;
  // Mode and cause only matter for vectoring.
  logic unused_vec_fields;
  assign unused_vec_fields = ^{curr_mtvec.mode, next_mcause};
`endif

  always_comb begin
    evt    = EVT_NONE;
    target = trap_base;
    if (intr) begin
      evt    = EVT_INTR;
      target = trap_target;
    end else if (mret) begin
      evt    = EVT_MRET;
      target = align_pc(curr_mepc);
    end else if (sret) begin
      evt    = EVT_SRET;
      target = align_pc(curr_sepc);
    end
  end

endmodule

// File: rtl/priv_1_12_trap_redirect.sv
// Trap/return redirect FSM: latches the target, waits for pipeline drain, drives fetch.
// Latency: event with pipe_clear -> insert_pc next cycle; otherwise the cycle after pipe_clear.
// Backpressure: insert_pc/priv_pc held stable until fetch_ack; one-deep pending intr slot.
// Ports: CLK, RST (sync, active-high), bus (priv_1_12_trap_redirect_if.slave).
// Parameter RESET_PC: priv_pc value after reset. Optional macro: PRIV_1_12_VECTORED_TRAP_EN.
module priv_1_12_trap_redirect
  import machine_mode_types_1_12_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                          CLK,
  input  logic                          RST,
  priv_1_12_trap_redirect_if.slave      bus
);

  redirect_state_t state_q, state_d;
  logic [31:0]     target_q, target_d;
  logic [31:0]     pend_target_q, pend_target_d;
  logic            pend_valid_q, pend_valid_d;
  logic [31:0]     priv_pc_q, priv_pc_d;

  trap_evt_t       evt;
  logic [31:0]     evt_target;

  priv_1_12_trap_target u_trap_target (
    .intr        (bus.intr),
    .mret        (bus.mret),
    .sret        (bus.sret),
    .curr_mtvec  (bus.curr_mtvec),
    .curr_mepc   (bus.curr_mepc),
    .curr_sepc   (bus.curr_sepc),
    .next_mcause (bus.next_mcause),
    .evt         (evt),
    .target      (evt_target)
  );

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    pend_target_d = pend_target_q;
    pend_valid_d  = pend_valid_q;
    priv_pc_d     = priv_pc_q;

    case (state_q)
      IDLE: begin
        if (evt != EVT_NONE) begin
          target_d = evt_target;
          if (bus.pipe_clear) begin
            state_d   = REDIRECT;
            priv_pc_d = evt_target;
          end else begin
            state_d = WAIT_CLEAR;
          end
        end
      end

      WAIT_CLEAR: begin
        // A trap supersedes a latched return; late returns are ignored.
        if (evt == EVT_INTR) begin
          target_d = evt_target;
        end
        if (bus.pipe_clear) begin
          state_d   = REDIRECT;
          priv_pc_d = (evt == EVT_INTR) ? evt_target : target_q;
        end
      end

      REDIRECT: begin
        if (evt == EVT_INTR) begin
          pend_valid_d  = 1'b1;
          pend_target_d = evt_target;
        end
        if (bus.fetch_ack) begin
          // An intr landing in the ack cycle itself is treated as pending too,
          // otherwise it would be lost on the way back to IDLE.
          if (pend_valid_q || (evt == EVT_INTR)) begin
            state_d      = WAIT_CLEAR;
            target_d     = (evt == EVT_INTR) ? evt_target : pend_target_q;
            pend_valid_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      target_q      <= RESET_PC;
      pend_target_q <= RESET_PC;
      pend_valid_q  <= 1'b0;
      priv_pc_q     <= RESET_PC;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      pend_target_q <= pend_target_d;
      pend_valid_q  <= pend_valid_d;
      priv_pc_q     <= priv_pc_d;
    end
  end

  assign bus.insert_pc     = (state_q == REDIRECT);
  assign bus.priv_pc       = priv_pc_q;
  assign bus.redirect_busy = (state_q != IDLE);

endmodule
